// File: rtl/relaxed_delay_monitor_pkg.sv
// relaxed_delay_pkg: limits and arithmetic helpers shared by the relaxed delay monitor.
package relaxed_delay_pkg;
    localparam int MAX_NCH     = 16;
    localparam int MAX_DLY_LIM = 32;
    localparam int LAT_W       = $clog2(MAX_DLY_LIM) + 1;

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction
endpackage

// File: rtl/relaxed_delay_monitor_channel.sv
// rdm_channel: one trigger/response channel; ages open obligations and flags expiries.
// Coverage outputs exist only when RELAXED_DELAY_MONITOR_COVER_EN is defined.
module rdm_channel
    import relaxed_delay_pkg::*;
#(
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    input  logic resp_i,
    output logic err_pulse_o,
    output logic err_sticky_o,
    output logic pending_o
`ifdef RELAXED_DELAY_MONITOR_COVER_EN
    ,
    output logic [MAX_DLY:1]  sat_o,
    output logic [LAT_W-1:0]  lat_o
`endif
);
    logic [MAX_DLY:1] pend_q, pend_d, sat;
    logic             err_q, sticky_q, err_d;

    always_comb begin
        sat    = '0;
        pend_d = '0;
        for (int a = MIN_DLY; a <= MAX_DLY; a++) sat[a] = pend_q[a] & resp_i;
        pend_d[1] = trig_i;
        for (int a = 2; a <= MAX_DLY; a++) pend_d[a] = pend_q[a-1] & ~sat[a-1];
        err_d = pend_q[MAX_DLY] & ~resp_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            err_q    <= err_d;
            sticky_q <= sticky_q | err_d;
        end
    end

    assign err_pulse_o  = err_q;
    assign err_sticky_o = sticky_q;
    assign pending_o    = |pend_q;

`ifdef RELAXED_DELAY_MONITOR_COVER_EN
    logic [LAT_W-1:0] lat_q, lat_d;

    // Scan downwards so the youngest satisfied age wins.
    always_comb begin
        lat_d = lat_q;
        for (int a = MAX_DLY; a >= 1; a--) if (sat[a]) lat_d = LAT_W'(a);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lat_q <= '0;
        else     lat_q <= lat_d;
    end

    assign sat_o = sat;
    assign lat_o = lat_q;
`endif
endmodule

// File: rtl/relaxed_delay_monitor.sv
// relaxed_delay_monitor: per-channel trig |-> ##[MIN_DLY:MAX_DLY] resp checker with a shared failure count.
// Define RELAXED_DELAY_MONITOR_COVER_EN to add pass_cnt and last_lat coverage outputs.
module relaxed_delay_monitor
    import relaxed_delay_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int MIN_DLY = 1,
    parameter int MAX_DLY = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   trig,
    input  logic [NCH-1:0]   resp,
    output logic [NCH-1:0]   err_pulse,
    output logic [NCH-1:0]   err_sticky,
    output logic [NCH-1:0]   pending,
    output logic [CNT_W-1:0] fail_cnt
`ifdef RELAXED_DELAY_MONITOR_COVER_EN
    ,
    output logic [CNT_W-1:0]           pass_cnt,
    output logic [NCH-1:0][LAT_W-1:0]  last_lat
`endif
);
    if (MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > MAX_DLY_LIM || NCH < 1 || NCH > MAX_NCH)
    begin : g_bad_params
        $error("relaxed_delay_monitor: illegal NCH/MIN_DLY/MAX_DLY");
    end

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] fail_q, fail_d;

`ifdef RELAXED_DELAY_MONITOR_COVER_EN
    logic [MAX_DLY:1] sat_w [NCH];
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        rdm_channel #(.MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY)) u_ch (
            .clk         (clk),
            .rst         (rst),
            .trig_i      (trig[c]),
            .resp_i      (resp[c]),
            .err_pulse_o (err_pulse[c]),
            .err_sticky_o(err_sticky[c]),
            .pending_o   (pending[c])
`ifdef RELAXED_DELAY_MONITOR_COVER_EN
            ,
            .sat_o       (sat_w[c]),
            .lat_o       (last_lat[c])
`endif
        );
    end

    assign fail_d = CNT_W'(sat_add(32'(fail_q), 32'(popcount(32'(err_pulse))), CNT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fail_q <= '0;
        else     fail_q <= fail_d;
    end

    assign fail_cnt = fail_q;

`ifdef RELAXED_DELAY_MONITOR_COVER_EN
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [31:0]      pass_inc;

    always_comb begin
        pass_inc = '0;
        for (int i = 0; i < NCH; i++) pass_inc = pass_inc + 32'(popcount(32'(sat_w[i])));
        pass_d = CNT_W'(sat_add(32'(pass_q), pass_inc, CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pass_q <= '0;
        else     pass_q <= pass_d;
    end

    assign pass_cnt = pass_q;
`endif
endmodule

// File: tb/tb_relaxed_delay_monitor.sv
// tb_relaxed_delay_monitor: table-driven and hand-sequenced checks over three parameterisations.
module tb_relaxed_delay_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] trig_a, resp_a, trig_b, resp_b, trig_c, resp_c;
    logic [1:0] pulse_a, sticky_a, pend_a, pulse_b, sticky_b, pend_b, pulse_c, sticky_c, pend_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    relaxed_delay_monitor #(.NCH(2), .MIN_DLY(1), .MAX_DLY(2), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .trig(trig_a), .resp(resp_a),
        .err_pulse(pulse_a), .err_sticky(sticky_a), .pending(pend_a), .fail_cnt(cnt_a));

    relaxed_delay_monitor #(.NCH(2), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .trig(trig_b), .resp(resp_b),
        .err_pulse(pulse_b), .err_sticky(sticky_b), .pending(pend_b), .fail_cnt(cnt_b));

    relaxed_delay_monitor #(.NCH(2), .MIN_DLY(1), .MAX_DLY(2), .CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .trig(trig_c), .resp(resp_c),
        .err_pulse(pulse_c), .err_sticky(sticky_c), .pending(pend_c), .fail_cnt(cnt_c));

    typedef struct {
        logic       rst;
        logic [1:0] trig;
        logic [1:0] resp;
        logic [1:0] pulse;
        logic [1:0] sticky;
        logic [1:0] pend;
        logic [7:0] cnt;
    } vec_t;

    vec_t tab[26];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tab[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[1]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[2]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'd0};
        tab[3]  = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[4]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 8'd0};
        tab[6]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 8'd0};
        tab[7]  = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 8'd0};
        tab[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 8'd1};
        tab[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 8'd1};
        tab[10] = '{1'b0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 8'd1};
        tab[11] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 8'd1};
        tab[12] = '{1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 8'd1};
        tab[13] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 8'd1};
        tab[14] = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 8'd1};
        tab[15] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 8'd1};
        tab[16] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 8'd2};
        tab[17] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 8'd3};
        tab[18] = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 8'd3};
        tab[19] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[20] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[21] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 8'd0};
        tab[22] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 8'd0};
        tab[23] = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 8'd0};
        tab[24] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 8'd0};
        tab[25] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 8'd1};

        rst = 1'b1;
        {trig_a, resp_a, trig_b, resp_b, trig_c, resp_c} = '0;

        for (int i = 0; i < 26; i++) begin
            rst    = tab[i].rst;
            trig_a = tab[i].trig;
            resp_a = tab[i].resp;
            tick();
            chk("a_pulse", i, 32'(pulse_a), 32'(tab[i].pulse));
            chk("a_sticky", i, 32'(sticky_a), 32'(tab[i].sticky));
            chk("a_pending", i, 32'(pend_a), 32'(tab[i].pend));
            chk("a_fail_cnt", i, 32'(cnt_a), 32'(tab[i].cnt));
        end
        trig_a = '0;
        resp_a = '0;

        // Two overlapping triggers, one late response satisfies both.
        trig_b = 2'b01; tick(); chk("b_pend_open", 0, 32'(pend_b), 32'h1);
        trig_b = 2'b01; tick();
        trig_b = 2'b00; tick(); chk("b_pend_two", 0, 32'(pend_b), 32'h1);
        resp_b = 2'b01; tick();
        chk("b_pend_cleared", 0, 32'(pend_b), 32'h0);
        chk("b_pulse_none", 0, 32'(pulse_b), 32'h0);
        resp_b = 2'b00; tick();
        chk("b_pulse_none", 1, 32'(pulse_b), 32'h0);
        chk("b_sticky_none", 0, 32'(sticky_b), 32'h0);
        chk("b_cnt_zero", 0, 32'(cnt_b), 32'h0);

        // Response one cycle too early is ignored; obligation expires.
        trig_b = 2'b01; tick();
        trig_b = 2'b00; resp_b = 2'b01; tick();
        chk("b_early_pend", 0, 32'(pend_b), 32'h1);
        resp_b = 2'b00; tick();
        chk("b_early_pulse", 0, 32'(pulse_b), 32'h0);
        chk("b_early_pend", 1, 32'(pend_b), 32'h1);
        tick();
        chk("b_early_pulse", 1, 32'(pulse_b), 32'h1);
        chk("b_early_pend", 2, 32'(pend_b), 32'h0);
        tick();
        chk("b_early_pulse", 2, 32'(pulse_b), 32'h0);
        chk("b_early_sticky", 0, 32'(sticky_b), 32'h1);
        chk("b_early_cnt", 0, 32'(cnt_b), 32'h1);

        // Two-bit counter saturates at 3 under repeated dual failures.
        for (int r = 0; r < 3; r++) begin
            trig_c = 2'b11; tick();
            if (r > 0) chk("c_cnt_round", r, 32'(cnt_c), (r == 1) ? 32'h2 : 32'h3);
            trig_c = 2'b00; tick(); tick();
            chk("c_pulse", r, 32'(pulse_c), 32'h3);
        end
        tick(); chk("c_cnt_sat", 0, 32'(cnt_c), 32'h3);
        tick(); chk("c_cnt_sat", 1, 32'(cnt_c), 32'h3);
        chk("c_sticky", 0, 32'(sticky_c), 32'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
